// File: rtl/forthsuper_pkg.sv
// Shared forthsuper definitions: character constants, the loader state enum
// and a character classifier reused by the outer interpreter and atoi.
// Optional feature macro: TIB_ECHO_EN adds the ECH (echo) state.
package forthsuper_pkg;

  localparam logic [7:0] NUL   = 8'h00;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SP    = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;
  localparam logic [7:0] DEL   = 8'h7F;

  typedef enum logic [2:0] {
    RCV,
    WR,
    TRM,
    RDY
`ifdef TIB_ECHO_EN
    , ECH
`endif
  } tib_state_t;

  typedef enum logic [1:0] {
    CH_PRINT,
    CH_ERASE,
    CH_EOL,
    CH_OTHER
  } char_class_t;

  // TAB counts as printable; it is stored as a space by the loader.
  function automatic char_class_t char_class(input logic [7:0] c);
    if ((c >= SP && c <= TILDE) || c == TAB) return CH_PRINT;
    if (c == BS || c == DEL) return CH_ERASE;
    if (c == CR || c == LF) return CH_EOL;
    return CH_OTHER;
  endfunction

endpackage

// File: rtl/mb8_io.sv
// Byte-wide memory write bus: we = write enable, ai = address, vi = data.
interface mb8_io #(
  parameter int MSZ = 8,
  parameter int ASZ = 17
) ();
  logic           we;
  logic [ASZ-1:0] ai;
  logic [MSZ-1:0] vi;

  modport master (output we, output ai, output vi);
  modport slave  (input we, input ai, input vi);
endinterface

// File: rtl/tib_loader.sv
// Terminal input buffer loader: collects a line of characters from a byte
// stream into memory at TIB, handles backspace, terminates the line with NUL
// and holds it until the consumer acknowledges it.
// Optional feature macro: TIB_ECHO_EN (echo accepted characters on tx_*).
//
// state | meaning
// RCV   | waiting for an incoming byte (only state with rx_rdy=1)
// WR    | storing a printable byte, or dropping it when the buffer is full
// TRM   | writing the NUL terminator at TIB+len
// RDY   | complete line present, waiting for ack
// ECH   | (echo builds only) presenting the accepted byte on tx until taken
module tib_loader
  import forthsuper_pkg::*;
#(
  parameter int unsigned TIB    = 'h0,
  parameter int unsigned TIB_SZ = 256,
  parameter int          MSZ    = 8,
  parameter int          ASZ    = 17
) (
  input  logic           clk,
  input  logic           rst,
  mb8_io.master          mb_if,
  input  logic           rx_vld,
  input  logic [MSZ-1:0] rx_dat,
  output logic           rx_rdy,
  input  logic           ack,
  output logic           rdy,
  output logic [ASZ-1:0] len,
  output logic           ovf
`ifdef TIB_ECHO_EN
  ,
  output logic           tx_vld,
  output logic [MSZ-1:0] tx_dat,
  input  logic           tx_rdy
`endif
);

  localparam logic [ASZ-1:0] TIB_A   = ASZ'(TIB);
  // Last slot is reserved for the terminator, so len tops out one short.
  localparam logic [ASZ-1:0] LEN_MAX = ASZ'(TIB_SZ - 1);

  tib_state_t     state;
  char_class_t    cls;
  logic [MSZ-1:0] chr;

`ifdef TIB_ECHO_EN
  // Set when the echo in progress is the line end, so ECH proceeds to TRM.
  logic ech_trm;
`endif

  // Classify the incoming byte; anything with bits above the low byte set is
  // treated as an ignorable control byte.
  always_comb begin
    cls = char_class(8'(rx_dat));
    if (MSZ > 8 && (rx_dat >> 8) != '0) cls = CH_OTHER;
    chr = (rx_dat == MSZ'(TAB)) ? MSZ'(SP) : rx_dat;
  end

  // Line-assembly FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RCV;
      len      <= '0;
      ovf      <= 1'b0;
      rdy      <= 1'b0;
      rx_rdy   <= 1'b0;
      mb_if.we <= 1'b0;
      mb_if.ai <= TIB_A;
      mb_if.vi <= '0;
`ifdef TIB_ECHO_EN
      tx_vld   <= 1'b0;
      tx_dat   <= '0;
      ech_trm  <= 1'b0;
`endif
    end else begin
      mb_if.we <= 1'b0;
      case (state)
        RCV: begin
          rx_rdy <= 1'b1;
          if (rx_vld && rx_rdy) begin
            case (cls)
              CH_PRINT: begin
                // The write is set up here so we is high for exactly the WR cycle.
                rx_rdy   <= 1'b0;
                state    <= WR;
                mb_if.we <= (len != LEN_MAX);
                mb_if.ai <= TIB_A + len;
                mb_if.vi <= chr;
`ifdef TIB_ECHO_EN
                tx_dat   <= chr;
`endif
              end
              CH_ERASE: begin
                if (len != '0) begin
                  len <= len - ASZ'(1);
`ifdef TIB_ECHO_EN
                  // Only echo an erase that actually removed a character.
                  rx_rdy  <= 1'b0;
                  tx_vld  <= 1'b1;
                  tx_dat  <= rx_dat;
                  ech_trm <= 1'b0;
                  state   <= ECH;
`endif
                end
              end
              CH_EOL: begin
                rx_rdy <= 1'b0;
`ifdef TIB_ECHO_EN
                tx_vld  <= 1'b1;
                tx_dat  <= rx_dat;
                ech_trm <= 1'b1;
                state   <= ECH;
`else
                state    <= TRM;
                mb_if.we <= 1'b1;
                mb_if.ai <= TIB_A + len;
                mb_if.vi <= MSZ'(NUL);
`endif
              end
              default: ;
            endcase
          end
        end

        WR: begin
          if (len != LEN_MAX) len <= len + ASZ'(1);
          else                ovf <= 1'b1;
`ifdef TIB_ECHO_EN
          if (len != LEN_MAX) begin
            tx_vld  <= 1'b1;
            ech_trm <= 1'b0;
            state   <= ECH;
          end else begin
            rx_rdy <= 1'b1;
            state  <= RCV;
          end
`else
          rx_rdy <= 1'b1;
          state  <= RCV;
`endif
        end

        TRM: begin
          rdy   <= 1'b1;
          state <= RDY;
        end

        RDY: begin
          if (ack) begin
            rdy    <= 1'b0;
            len    <= '0;
            ovf    <= 1'b0;
            rx_rdy <= 1'b1;
            state  <= RCV;
          end
        end

`ifdef TIB_ECHO_EN
        ECH: begin
          if (tx_rdy) begin
            tx_vld <= 1'b0;
            if (ech_trm) begin
              state    <= TRM;
              mb_if.we <= 1'b1;
              mb_if.ai <= TIB_A + len;
              mb_if.vi <= MSZ'(NUL);
            end else begin
              rx_rdy <= 1'b1;
              state  <= RCV;
            end
          end
        end
`endif

        default: begin
          rx_rdy <= 1'b0;
          state  <= RCV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tib_loader.sv
// Bench for tib_loader: directed line scenarios plus random lines checked
// against a queue-based line-editing model. Echo scenario only when
// TIB_ECHO_EN is defined.
module tb_tib_loader;

  localparam int unsigned TIB_BASE = 'h100;
  localparam int unsigned TSZ      = 8;
  localparam int          MSZ      = 8;
  localparam int          ASZ      = 17;

  typedef logic [7:0] bq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx_vld = 1'b0;
  logic [MSZ-1:0] rx_dat = '0;
  logic           rx_rdy;
  logic           ack = 1'b0;
  logic           rdy;
  logic [ASZ-1:0] len;
  logic           ovf;
`ifdef TIB_ECHO_EN
  logic           tx_vld;
  logic [MSZ-1:0] tx_dat;
  logic           tx_rdy = 1'b1;
  logic [7:0]     txlog[$];
`endif

  mb8_io #(.MSZ(MSZ), .ASZ(ASZ)) mb ();

  tib_loader #(.TIB(TIB_BASE), .TIB_SZ(TSZ), .MSZ(MSZ), .ASZ(ASZ)) dut (
    .clk(clk), .rst(rst), .mb_if(mb),
    .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
    .ack(ack), .rdy(rdy), .len(len), .ovf(ovf)
`ifdef TIB_ECHO_EN
    , .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy)
`endif
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [7:0] mem [int];
  int         wlog_a[$];
  logic [7:0] wlog_d[$];
  int         oor_cnt = 0;
  int         rdy_rx_viol = 0;

  // Memory model and write log fed from the DUT write port.
  always @(posedge clk) begin
    if (mb.we === 1'b1) begin
      wlog_a.push_back(int'(mb.ai));
      wlog_d.push_back(mb.vi);
      mem[int'(mb.ai)] = mb.vi;
      if (int'(mb.ai) < int'(TIB_BASE) || int'(mb.ai) >= int'(TIB_BASE + TSZ)) oor_cnt++;
    end
`ifdef TIB_ECHO_EN
    if (tx_vld === 1'b1 && tx_rdy === 1'b1) txlog.push_back(tx_dat);
`endif
  end

  always @(negedge clk) if (rdy === 1'b1 && rx_rdy === 1'b1) rdy_rx_viol++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected results of the reference model for one line.
  int         exp_a[$];
  logic [7:0] exp_d[$];
  int         exp_len;
  logic       exp_ovf;

  // Line-editing reference: a character list with a capacity of TSZ-1.
  task automatic model_line(input bq_t s);
    bq_t line;
    logic [7:0] c;
    exp_a.delete(); exp_d.delete(); exp_ovf = 1'b0;
    foreach (s[i]) begin
      c = s[i];
      if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h09) begin
        if (line.size() < int'(TSZ) - 1) begin
          exp_a.push_back(int'(TIB_BASE) + line.size());
          exp_d.push_back(c == 8'h09 ? 8'h20 : c);
          line.push_back(c == 8'h09 ? 8'h20 : c);
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (c == 8'h08 || c == 8'h7F) begin
        if (line.size() > 0) void'(line.pop_back());
      end else if (c == 8'h0D || c == 8'h0A) begin
        exp_a.push_back(int'(TIB_BASE) + line.size());
        exp_d.push_back(8'h00);
        break;
      end
    end
    exp_len = line.size();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) begin
      rx_vld = 1'b0;
      rx_dat = 8'($urandom);
      ack    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ack = 1'b0; rx_dat = b; rx_vld = 1'b1; n = 0;
    while (rx_rdy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_run++; n_fail++;
      $display("FAIL send_byte: rx_rdy stayed %b for 200 cycles, required 1", rx_rdy);
    end
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_run++; n_fail++;
      $display("FAIL %s rdy_timeout: rdy=%b after 100 cycles, required 1", name, rdy);
    end
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_run++;
    if (rdy !== 1'b0 || len !== '0 || ovf !== 1'b0 || rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_ack: rdy=%b len=%0d ovf=%b rx_rdy=%b, required 0 0 0 1",
               name, rdy, len, ovf, rx_rdy);
    end
  endtask

  // Send a whole line, check it against the model (and optional fixed
  // expectations), then acknowledge it.
  task automatic run_line(input string name, input bq_t s, input bq_t want, input int want_len);
    bit bad;
    logic [7:0] got;
    model_line(s);
    wlog_a.delete(); wlog_d.delete();
    foreach (s[i]) send_byte(s[i]);
    wait_rdy(name);
    repeat (2) @(negedge clk);
    n_run++;
    if (rdy !== 1'b1 || rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hold: rdy=%b rx_rdy=%b, required 1 0", name, rdy, rx_rdy);
    end
    n_run++;
    if (len !== ASZ'(exp_len) || ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s len_ovf: len=%0d ovf=%b, required %0d %b", name, len, ovf, exp_len, exp_ovf);
    end
    n_run++;
    bad = (wlog_a.size() != exp_a.size());
    if (!bad) foreach (exp_a[i]) if (wlog_a[i] != exp_a[i] || wlog_d[i] !== exp_d[i]) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL %s writes: %0d writes logged, required %0d (first want @%0h=%0h)",
               name, wlog_a.size(), exp_a.size(), exp_a[0], exp_d[0]);
    end
    if (want.size() > 0) begin
      n_run++;
      bad = (len !== ASZ'(want_len));
      foreach (want[i]) begin
        got = mem.exists(int'(TIB_BASE) + i) ? mem[int'(TIB_BASE) + i] : 8'hxx;
        if (got !== want[i]) bad = 1'b1;
      end
      if (bad) begin
        n_fail++;
        $display("FAIL %s mem: len=%0d mem[0]=%0h, required len=%0d mem[0]=%0h",
                 name, len, mem[int'(TIB_BASE)], want_len, want[0]);
      end
    end
    do_ack(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_run++;
    if (rx_rdy !== 1'b0 || rdy !== 1'b0 || len !== '0 || ovf !== 1'b0 ||
        mb.we !== 1'b0 || mb.ai !== ASZ'(TIB_BASE)) begin
      n_fail++;
      $display("FAIL reset_state: rx_rdy=%b rdy=%b len=%0d ovf=%b we=%b ai=%0h, required 0 0 0 0 0 %0h",
               rx_rdy, rdy, len, ovf, mb.we, mb.ai, TIB_BASE);
    end
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: rx_rdy=%b one cycle after release, required 1", rx_rdy);
    end
  endtask

  task automatic test_directed();
    bq_t s, w;
    s = '{8'h32, 8'h20, 8'h33, 8'h20, 8'h2B, 8'h0D};
    w = '{8'h32, 8'h20, 8'h33, 8'h20, 8'h2B, 8'h00};
    run_line("add_line", s, w, 5);
    s = '{8'h31, 8'h32, 8'h08, 8'h33, 8'h0D};
    w = '{8'h31, 8'h33, 8'h00};
    run_line("backspace", s, w, 2);
    s = '{8'h08, 8'h41, 8'h0D};
    w = '{8'h41, 8'h00};
    run_line("bs_at_zero", s, w, 1);
    s = '{8'h09, 8'h7F, 8'h01, 8'h5A, 8'h1B, 8'h0A};
    w = '{8'h5A, 8'h00};
    run_line("tab_del_ctrl_lf", s, w, 1);
  endtask

  task automatic test_overflow();
    bq_t s, w;
    s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h0D};
    w = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h00};
    run_line("overflow", s, w, 7);
  endtask

  task automatic test_ack_ignored();
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    n_run++;
    if (rdy !== 1'b0 || len !== '0 || rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_ignored: rdy=%b len=%0d rx_rdy=%b, required 0 0 1", rdy, len, rx_rdy);
    end
  endtask

  task automatic test_reset_midline();
    bq_t s, w;
    bit bad;
    wlog_a.delete(); wlog_d.delete();
    send_byte(8'h31);
    send_byte(8'h32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_run++;
    if (len !== '0 || rdy !== 1'b0 || rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_reset: len=%0d rdy=%b rx_rdy=%b, required 0 0 1", len, rdy, rx_rdy);
    end
    n_run++;
    bad = (wlog_a.size() != 2);
    foreach (wlog_a[i]) if (wlog_a[i] == int'(TIB_BASE) + 2) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL midline_writes: %0d writes logged, required 2 and none at offset 2", wlog_a.size());
    end
    s = '{8'h39, 8'h0D};
    w = '{8'h39, 8'h00};
    run_line("after_reset", s, w, 1);
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    case ($urandom_range(0, 9))
      0: c = 8'h09;
      1: c = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
      2: begin
        c = 8'($urandom_range(0, 31));
        while (c == 8'h08 || c == 8'h09 || c == 8'h0A || c == 8'h0D) c = 8'($urandom_range(0, 31));
      end
      default: c = 8'($urandom_range(32, 126));
    endcase
    return c;
  endfunction

  task automatic test_random();
    bq_t s, w;
    for (int k = 0; k < 15; k++) begin
      s.delete(); w.delete();
      for (int j = 0; j < int'($urandom_range(0, 12)); j++) s.push_back(rand_char());
      s.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      run_line($sformatf("random_%0d", k), s, w, 0);
    end
  endtask

`ifdef TIB_ECHO_EN
  task automatic test_echo();
    int n = 0;
    txlog.delete();
    tx_rdy = 1'b0;
    send_byte(8'h78);
    while (tx_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) begin
      n_run++;
      if (tx_vld !== 1'b1 || tx_dat !== 8'h78 || rx_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL echo_hold: tx_vld=%b tx_dat=%0h rx_rdy=%b, required 1 78 0", tx_vld, tx_dat, rx_rdy);
      end
      @(negedge clk);
    end
    tx_rdy = 1'b1;
    send_byte(8'h0D);
    wait_rdy("echo");
    n_run++;
    if (txlog.size() != 2 || txlog[0] !== 8'h78 || txlog[1] !== 8'h0D || len !== ASZ'(1)) begin
      n_fail++;
      $display("FAIL echo_order: %0d echoes len=%0d, required 2 echoes 78 0D and len 1", txlog.size(), len);
    end
    do_ack("echo");
  endtask
`endif

  initial begin
    test_reset();
    test_ack_ignored();
    test_directed();
    test_overflow();
    test_reset_midline();
    test_random();
`ifdef TIB_ECHO_EN
    test_echo();
`endif
    n_run++;
    if (oor_cnt != 0 || rdy_rx_viol != 0) begin
      n_fail++;
      $display("FAIL invariants: out_of_range_writes=%0d rx_rdy_during_rdy=%0d, required 0 0",
               oor_cnt, rdy_rx_viol);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
